// File: rtl/rv_dec_pkg.sv
// Shared decode definitions: RV32I base opcodes, the canonical NOP and the fetch->decode entry layout.
package rv_dec_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [31:0] NOP_ENC = 32'h00000013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ifid_entry_t;

   function automatic logic opc_known(input logic [6:0] opc);
      return (opc == OPC_LOAD)  || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
             (opc == OPC_JAL)   || (opc == OPC_JALR)  || (opc == OPC_OPIMM)  ||
             (opc == OPC_OP)    || (opc == OPC_LUI)   || (opc == OPC_AUIPC);
   endfunction

endpackage

// File: rtl/dec_receive_imm_gen.sv
// Combinational RV32I immediate generator; zero for R-type and unknown opcodes.
// Shared with the execute stage, so it must stay free of any decode-side state.
module imm_gen
   import rv_dec_pkg::*;
(
   input  logic [31:0] inst,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'h0;
      case (inst[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_JALR:
            imm = {{20{inst[31]}}, inst[31:20]};
         OPC_STORE:
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OPC_BRANCH:
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {inst[31:12], 12'h0};
         OPC_JAL:
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:
            imm = 32'h0;
      endcase
   end

endmodule

// File: rtl/dec_receive.sv
// Decode receiver: 2-entry skid buffer (push->head latency 1, fetch_ready low only when full), flush wins over push/pop.
// Define DEC_STATS_EN to add saturating issued/bubble counters.
module dec_receive
   import rv_dec_pkg::*;
#(
   parameter int          NUM_INST = 128,
   parameter logic [31:0] NOP_INST = NOP_ENC
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] fetch_dec_reg,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic        flush,
   input  logic        dec_ready,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_inst,
   output logic [6:0]  opcode,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  funct7,
   output logic [31:0] imm,
   output logic        dec_illegal
`ifdef DEC_STATS_EN
   ,
   output logic [31:0] stat_issued,
   output logic [31:0] stat_bubbles
`endif
);

   localparam logic [30:0] NUM_INST_L = 31'(NUM_INST);

   ifid_entry_t ent_q [2];
   ifid_entry_t ent_d [2];
   logic        head_q, head_d;
   logic [1:0]  count_q, count_d;
   logic        push, pop;
   ifid_entry_t head_ent;

   assign fetch_ready = (count_q != 2'd2);
   assign dec_valid   = (count_q != 2'd0);
   assign push        = fetch_valid & fetch_ready;
   assign pop         = dec_valid & dec_ready;
   assign head_ent    = ent_q[head_q];

   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         // Tail slot is head + count (mod 2); never reached with count=2.
         if (push)
            ent_d[head_q ^ count_q[0]] = ifid_entry_t'(fetch_dec_reg);
         if (pop)
            head_d = ~head_q;
         if (push && !pop)
            count_d = count_q + 2'd1;
         else if (pop && !push)
            count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         head_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         ent_q    <= ent_d;
         head_q   <= head_d;
         count_q  <= count_d;
      end
   end

   assign dec_inst = dec_valid ? head_ent.inst : NOP_INST;
   assign dec_pc   = dec_valid ? head_ent.pc   : 32'h0;
   assign opcode   = dec_inst[6:0];
   assign rd       = dec_inst[11:7];
   assign funct3   = dec_inst[14:12];
   assign rs1      = dec_inst[19:15];
   assign rs2      = dec_inst[24:20];
   assign funct7   = dec_inst[31:25];

   imm_gen u_imm_gen (
      .inst (dec_inst),
      .imm  (imm)
   );

   assign dec_illegal = dec_valid &
                        (!opc_known(dec_inst[6:0]) || (dec_inst[1:0] != 2'b11) ||
                         (dec_pc[1:0] != 2'b00) || ({1'b0, dec_pc[31:2]} >= NUM_INST_L));

`ifdef DEC_STATS_EN
   logic [31:0] issued_q, issued_d;
   logic [31:0] bubbles_q, bubbles_d;

   always_comb begin
      issued_d  = issued_q;
      bubbles_d = bubbles_q;
      if (pop && issued_q != 32'hFFFF_FFFF)
         issued_d = issued_q + 32'd1;
      if (dec_ready && !dec_valid && bubbles_q != 32'hFFFF_FFFF)
         bubbles_d = bubbles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         issued_q  <= 32'h0;
         bubbles_q <= 32'h0;
      end else begin
         issued_q  <= issued_d;
         bubbles_q <= bubbles_d;
      end
   end

   assign stat_issued  = issued_q;
   assign stat_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_dec_receive.sv
// Directed bench for dec_receive: reset, pass-through, backpressure, flush, immediates and illegal detection.
module tb_dec_receive;

   logic        clk = 1'b0;
   logic        rstn;
   logic [63:0] fetch_dec_reg;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        flush;
   logic        dec_ready;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        dec_illegal;
`ifdef DEC_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_bubbles;
`endif

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   dec_receive dut (
      .clk           (clk),
      .rstn          (rstn),
      .fetch_dec_reg (fetch_dec_reg),
      .fetch_valid   (fetch_valid),
      .fetch_ready   (fetch_ready),
      .flush         (flush),
      .dec_ready     (dec_ready),
      .dec_valid     (dec_valid),
      .dec_pc        (dec_pc),
      .dec_inst      (dec_inst),
      .opcode        (opcode),
      .rd            (rd),
      .funct3        (funct3),
      .rs1           (rs1),
      .rs2           (rs2),
      .funct7        (funct7),
      .imm           (imm),
      .dec_illegal   (dec_illegal)
`ifdef DEC_STATS_EN
      ,
      .stat_issued   (stat_issued),
      .stat_bubbles  (stat_bubbles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Push one word into an empty buffer with dec_ready low, leaving it at the head.
   task automatic push_head(input logic [31:0] inst, input logic [31:0] pc);
      fetch_dec_reg = {inst, pc};
      fetch_valid   = 1'b1;
      step();
      fetch_valid   = 1'b0;
   endtask

   task automatic pop_one();
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

   vec_t vecs [9] = '{
      '{32'hFE000EE3, 32'h40,  32'hFFFFFFFC, 1'b0},  // beq -4
      '{32'h0000007F, 32'h44,  32'h00000000, 1'b1},  // unknown opcode
      '{32'h00500093, 32'h200, 32'h00000005, 1'b1},  // pc = NUM_INST*4
      '{32'hFE512C23, 32'h48,  32'hFFFFFFF8, 1'b0},  // sw x5,-8(x2)
      '{32'h123450B7, 32'h4C,  32'h12345000, 1'b0},  // lui
      '{32'h008000EF, 32'h50,  32'h00000008, 1'b0},  // jal +8
      '{32'h00500093, 32'h42,  32'h00000005, 1'b1},  // misaligned pc
      '{32'h002081B3, 32'h1FC, 32'h00000000, 1'b0},  // add, last legal pc
      '{32'h00500091, 32'h54,  32'h00000000, 1'b1}   // inst[1:0] != 11
   };

   initial begin
      rstn          = 1'b0;
      fetch_dec_reg = '0;
      fetch_valid   = 1'b0;
      flush         = 1'b0;
      dec_ready     = 1'b0;
      step();
      step();
      rstn = 1'b1;

      chk("rst_valid", {31'b0, dec_valid}, 32'd0);
      chk("rst_inst", dec_inst, 32'h00000013);
      chk("rst_pc", dec_pc, 32'h0);
      chk("rst_ready", {31'b0, fetch_ready}, 32'd1);
      chk("rst_imm", imm, 32'h0);
      chk("rst_ill", {31'b0, dec_illegal}, 32'd0);
      chk("rst_opcode", {25'b0, opcode}, 32'h13);

      // Single pass-through with dec_ready held high
      dec_ready     = 1'b1;
      fetch_dec_reg = {32'h00500093, 32'h00000004};
      fetch_valid   = 1'b1;
      step();
      fetch_valid   = 1'b0;
      chk("pt_valid", {31'b0, dec_valid}, 32'd1);
      chk("pt_rd", {27'b0, rd}, 32'd1);
      chk("pt_rs1", {27'b0, rs1}, 32'd0);
      chk("pt_imm", imm, 32'd5);
      chk("pt_pc", dec_pc, 32'h4);
      chk("pt_ill", {31'b0, dec_illegal}, 32'd0);
      step();
      chk("pt_empty", {31'b0, dec_valid}, 32'd0);

      // Backpressure and fill
      dec_ready = 1'b0;
      push_head(32'h00100093, 32'h08);
      push_head(32'h00200093, 32'h0C);
      chk("bp_full_rdy", {31'b0, fetch_ready}, 32'd0);
      chk("bp_head0", dec_pc, 32'h08);
      fetch_dec_reg = {32'h00300093, 32'h10};
      fetch_valid   = 1'b1;
      step();
      step();
      chk("bp_hold_rdy", {31'b0, fetch_ready}, 32'd0);
      chk("bp_hold_head", dec_pc, 32'h08);
      dec_ready = 1'b1;
      step();
      chk("bp_pop1_pc", dec_pc, 32'h0C);
      chk("bp_pop1_rdy", {31'b0, fetch_ready}, 32'd1);
      step();
      fetch_valid = 1'b0;
      chk("bp_pop2_pc", dec_pc, 32'h10);
      chk("bp_pop2_inst", dec_inst, 32'h00300093);
      chk("bp_pop2_vld", {31'b0, dec_valid}, 32'd1);
      step();
      chk("bp_drained", {31'b0, dec_valid}, 32'd0);
      dec_ready = 1'b0;

      // Flush with a full buffer and a word on the bus
      push_head(32'h00400093, 32'h20);
      push_head(32'h00500093, 32'h24);
      flush         = 1'b1;
      dec_ready     = 1'b1;
      fetch_dec_reg = {32'h00600093, 32'h28};
      fetch_valid   = 1'b1;
      step();
      flush       = 1'b0;
      fetch_valid = 1'b0;
      dec_ready   = 1'b0;
      chk("fl_full_vld", {31'b0, dec_valid}, 32'd0);
      chk("fl_full_rdy", {31'b0, fetch_ready}, 32'd1);
      step();
      chk("fl_full_gone", {31'b0, dec_valid}, 32'd0);

      // Flush with one entry: fetch_ready stays high in the flush cycle
      push_head(32'h00700093, 32'h30);
      flush         = 1'b1;
      fetch_dec_reg = {32'h00800093, 32'h34};
      fetch_valid   = 1'b1;
      #1;
      chk("fl_one_rdy", {31'b0, fetch_ready}, 32'd1);
      step();
      flush       = 1'b0;
      fetch_valid = 1'b0;
      chk("fl_one_vld", {31'b0, dec_valid}, 32'd0);
      chk("fl_one_inst", dec_inst, 32'h00000013);

      // Immediate and illegal vectors
      foreach (vecs[i]) begin
         push_head(vecs[i].inst, vecs[i].pc);
         chk($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
         chk($sformatf("vec%0d_ill", i), {31'b0, dec_illegal}, {31'b0, vecs[i].ill});
         chk($sformatf("vec%0d_pc", i), dec_pc, vecs[i].pc);
         pop_one();
      end
      chk("vec_empty", {31'b0, dec_valid}, 32'd0);

      // Reset mid-operation drops everything
      push_head(32'h00100093, 32'h60);
      push_head(32'h00200093, 32'h64);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("mrst_vld", {31'b0, dec_valid}, 32'd0);
      chk("mrst_rdy", {31'b0, fetch_ready}, 32'd1);
      chk("mrst_inst", dec_inst, 32'h00000013);

`ifdef DEC_STATS_EN
      chk("st_rst_iss", stat_issued, 32'd0);
      chk("st_rst_bub", stat_bubbles, 32'd0);
      push_head(32'h00100093, 32'h70);
      push_head(32'h00200093, 32'h74);
      dec_ready = 1'b1;
      step();
      step();
      dec_ready = 1'b0;
      push_head(32'h00300093, 32'h78);
      dec_ready = 1'b1;
      step();
      for (int k = 0; k < 4; k++) step();
      dec_ready = 1'b0;
      chk("st_issued", stat_issued, 32'd3);
      chk("st_bubbles", stat_bubbles, 32'd4);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("st_clr_iss", stat_issued, 32'd0);
      chk("st_clr_bub", stat_bubbles, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
